// File: rtl/serial_db_pkg.sv
// rtl/serial_db_pkg.sv - shared states, response words and header layout for the serial burst driver
package serial_db_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RX_ADDR,
        S_RX_DATA,
        S_RX_SUM,
        S_TX_ACK,
        S_TX_NACK,
        S_ISSUE,
        S_WAIT_CTRLR,
        S_TX_DATA,
        S_TX_STATUS
    } sdrv_state_e;

    localparam logic [31:0] ACK_WORD = 32'h0000_00A5;
    localparam logic [31:0] NACK_SUM = 32'h0000_0E01;
    localparam logic [31:0] NACK_LEN = 32'h0000_0E02;

    localparam int HDR_CMD_LSB = 0;
    localparam int HDR_CMD_W   = 4;
    localparam int HDR_LEN_LSB = 8;
    localparam int HDR_LEN_W   = 8;

    localparam logic [3:0] FN_MEM_WR_WORD = 4'hC;

endpackage

// File: rtl/sdrv_burst_buf.sv
// rtl/sdrv_burst_buf.sv - burst write-data register file, one sync write port, one combinational read port
module sdrv_burst_buf #(
    parameter int DEPTH = 16,
    parameter int IW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [IW-1:0] widx_i,
    input  logic [31:0]   wdata_i,
    input  logic [IW-1:0] ridx_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[widx_i] <= wdata_i;
    end

    assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/uart_rx_word.sv
// rtl/uart_rx_word.sv - 8N1 UART receiver assembling four bytes (LSB first) into a 32-bit word
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        rx_i,
    output logic [31:0] data_o,
    output logic        ready_o
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_BITS, R_STOP} rx_state_e;

    rx_state_e     state_q;
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [1:0]    byte_q;
    logic [7:0]    shift_q;
    logic [31:0]   word_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= R_IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            word_q  <= '0;
            data_o  <= '0;
            ready_o <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            ready_o <= 1'b0;
            case (state_q)
                R_IDLE: if (!sync_q[1]) begin
                    state_q <= R_START;
                    cnt_q   <= '0;
                end
                R_START: if (cnt_q == HALF) begin
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    state_q <= sync_q[1] ? R_IDLE : R_BITS;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                R_BITS: if (cnt_q == LAST) begin
                    cnt_q   <= '0;
                    shift_q <= {sync_q[1], shift_q[7:1]};
                    bit_q   <= bit_q + 3'd1;
                    if (bit_q == 3'd7) state_q <= R_STOP;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: if (cnt_q == LAST) begin
                    cnt_q   <= '0;
                    state_q <= R_IDLE;
                    word_q  <= {shift_q, word_q[31:8]};
                    byte_q  <= byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        data_o  <= {shift_q, word_q[31:8]};
                        ready_o <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_word.sv
// rtl/uart_tx_word.sv - 8N1 UART transmitter sending a 32-bit word as four bytes, LSB first
module uart_tx_word #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic [31:0] data_i,
    output logic        busy_o,
    output logic        tx_o
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [1:0]    byte_q;
    logic [9:0]    frame_q;
    logic [31:0]   word_q;

    assign tx_o = frame_q[0];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_o  <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            frame_q <= '1;
            word_q  <= '0;
        end else if (!busy_o) begin
            if (start_i) begin
                busy_o  <= 1'b1;
                word_q  <= data_i;
                frame_q <= {1'b1, data_i[7:0], 1'b0};
                cnt_q   <= '0;
                bit_q   <= '0;
                byte_q  <= '0;
            end
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (bit_q == 4'd9) begin
                bit_q <= '0;
                if (byte_q == 2'd3) begin
                    busy_o <= 1'b0;
                end else begin
                    byte_q  <= byte_q + 2'd1;
                    word_q  <= word_q >> 8;
                    frame_q <= {1'b1, word_q[15:8], 1'b0};
                end
            end else begin
                bit_q   <= bit_q + 4'd1;
                frame_q <= {1'b1, frame_q[9:1]};
            end
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/serial_burst_driver.sv
// rtl/serial_burst_driver.sv - checksummed UART command packets turned into per-beat controller transactions
module serial_burst_driver
    import serial_db_pkg::*;
#(
    parameter int          CLK_RATE    = 50,
    parameter int          BAUD        = 115200,
    parameter int          TIMEOUT     = 200,
    parameter int          MAX_BURST   = 16,
    parameter int          ADDR_STRIDE = 4,
    parameter logic [15:0] WRITE_MASK  = 16'h1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        srx,
    output logic        stx,
    input  logic        ctrlr_busy,
    input  logic [31:0] d_rd,
    input  logic [1:0]  error,
    output logic [3:0]  cmd,
    output logic [31:0] addr,
    output logic [31:0] d_in,
    output logic        out_valid
);
    localparam int          CLKS_PER_BIT = CLK_RATE * 1_000_000 / BAUD;
    localparam logic [31:0] TMO_LIMIT    = 32'(longint'(TIMEOUT) * CLK_RATE * 1000);
    localparam int          IW           = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [8:0]  MAX_N        = 9'(MAX_BURST);

    sdrv_state_e state_q;
    logic [3:0]  cmd_q;
    logic [8:0]  n_q, k_q;
    logic [31:0] base_q, acc_q, tmo_q, tx_data_q, addr_q, d_in_q;
    logic [1:0]  err_q;
    logic        tx_start_q, out_valid_q;

    logic [31:0] rx_data, buf_rdata, issue_addr, issue_din;
    logic        rx_ready, tx_busy, tx_done, is_write, in_rx;
    logic [8:0]  rx_len_n, issue_k;

    assign rx_len_n   = {1'b0, rx_data[HDR_LEN_LSB +: HDR_LEN_W]} + 9'd1;
    assign is_write   = WRITE_MASK[cmd_q];
    assign in_rx      = state_q inside {S_RX_ADDR, S_RX_DATA, S_RX_SUM};
    assign tx_done    = !tx_start_q && !tx_busy;
    // Beat index about to be issued: 0 right after the ACK, otherwise the next beat.
    assign issue_k    = (state_q == S_TX_ACK) ? 9'd0 : k_q + 9'd1;
    assign issue_addr = base_q + {23'd0, issue_k} * 32'(ADDR_STRIDE);
    assign issue_din  = is_write ? buf_rdata : 32'd0;

    assign cmd       = cmd_q;
    assign addr      = addr_q;
    assign d_in      = d_in_q;
    assign out_valid = out_valid_q;

    uart_rx_word #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i(clk), .rst_n_i(reset_n), .rx_i(srx), .data_o(rx_data), .ready_o(rx_ready)
    );

    uart_tx_word #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk_i(clk), .rst_n_i(reset_n), .start_i(tx_start_q), .data_i(tx_data_q),
        .busy_o(tx_busy), .tx_o(stx)
    );

    sdrv_burst_buf #(.DEPTH(MAX_BURST), .IW(IW)) u_buf (
        .clk_i(clk), .we_i(state_q == S_RX_DATA && rx_ready), .widx_i(k_q[IW-1:0]),
        .wdata_i(rx_data), .ridx_i(issue_k[IW-1:0]), .rdata_o(buf_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            n_q         <= '0;
            k_q         <= '0;
            base_q      <= '0;
            acc_q       <= '0;
            tmo_q       <= '0;
            err_q       <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            out_valid_q <= 1'b0;
            addr_q      <= '0;
            d_in_q      <= '0;
        end else begin
            tx_start_q  <= 1'b0;
            out_valid_q <= 1'b0;
            tmo_q       <= (in_rx && !rx_ready) ? tmo_q + 32'd1 : 32'd0;
            if (in_rx && !rx_ready && tmo_q > TMO_LIMIT) state_q <= S_IDLE;
            case (state_q)
                S_IDLE: if (rx_ready) begin
                    cmd_q <= rx_data[HDR_CMD_LSB +: HDR_CMD_W];
                    n_q   <= rx_len_n;
                    acc_q <= rx_data;
                    err_q <= '0;
                    if (rx_len_n > MAX_N) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= NACK_LEN;
                        state_q    <= S_TX_NACK;
                    end else begin
                        state_q <= S_RX_ADDR;
                    end
                end
                S_RX_ADDR: if (rx_ready) begin
                    base_q  <= rx_data;
                    acc_q   <= acc_q ^ rx_data;
                    k_q     <= '0;
                    state_q <= is_write ? S_RX_DATA : S_RX_SUM;
                end
                S_RX_DATA: if (rx_ready) begin
                    acc_q <= acc_q ^ rx_data;
                    k_q   <= k_q + 9'd1;
                    if (k_q + 9'd1 == n_q) state_q <= S_RX_SUM;
                end
                S_RX_SUM: if (rx_ready) begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= (rx_data == acc_q) ? ACK_WORD : NACK_SUM;
                    state_q    <= (rx_data == acc_q) ? S_TX_ACK : S_TX_NACK;
                end
                S_TX_ACK: if (tx_done) begin
                    k_q         <= issue_k;
                    addr_q      <= issue_addr;
                    d_in_q      <= issue_din;
                    out_valid_q <= 1'b1;
                    state_q     <= S_ISSUE;
                end
                S_ISSUE: state_q <= S_WAIT_CTRLR;
                S_WAIT_CTRLR: if (!ctrlr_busy && !out_valid_q) begin
                    tx_start_q <= 1'b1;
                    tx_data_q  <= d_rd;
                    err_q      <= err_q | error;
                    state_q    <= S_TX_DATA;
                end
                S_TX_DATA: if (tx_done) begin
                    if (issue_k < n_q) begin
                        k_q         <= issue_k;
                        addr_q      <= issue_addr;
                        d_in_q      <= issue_din;
                        out_valid_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end else begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= {30'd0, err_q};
                        state_q    <= S_TX_STATUS;
                    end
                end
                S_TX_NACK, S_TX_STATUS: if (tx_done) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_burst_driver.sv
// tb/tb_serial_burst_driver.sv - bench for serial_burst_driver: UART host, controller model, packet reference model
module tb_serial_burst_driver;

    localparam int          CPB    = 4;
    localparam int          MAXB   = 16;
    localparam int          STRIDE = 4;
    localparam logic [15:0] WMASK  = 16'h1000;

    logic        clk, reset_n, srx, stx, ctrlr_busy, out_valid;
    logic [31:0] d_rd, addr, d_in;
    logic [1:0]  error;
    logic [3:0]  cmd;

    int tests = 0;
    int fails = 0;
    int ctl_lat = 0;
    int tx_cnt = 0;
    int ov_cnt = 0;

    logic [31:0] tx_arr [0:255];
    logic [67:0] ov_arr [0:255];
    logic [33:0] resp_arr [0:255];
    logic [31:0] data_q [$];
    logic [33:0] resp_q [$];

    serial_burst_driver #(
        .CLK_RATE(1), .BAUD(250000), .TIMEOUT(1), .MAX_BURST(MAXB),
        .ADDR_STRIDE(STRIDE), .WRITE_MASK(WMASK)
    ) dut (
        .clk(clk), .reset_n(reset_n), .srx(srx), .stx(stx), .ctrlr_busy(ctrlr_busy),
        .d_rd(d_rd), .error(error), .cmd(cmd), .addr(addr), .d_in(d_in), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    // Host-side UART receiver: decodes stx into words, LSB byte first.
    initial begin : tx_mon
        logic [31:0] w;
        logic [7:0]  b;
        forever begin
            for (int by = 0; by < 4; by++) begin
                @(negedge clk);
                while (stx !== 1'b0) @(negedge clk);
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = stx;
                end
                repeat (CPB) @(negedge clk);
                w[by*8 +: 8] = b;
            end
            tx_arr[tx_cnt] = w;
            tx_cnt++;
        end
    end

    // Controller: records each strobe, answers with the preloaded response after ctl_lat busy cycles.
    initial begin : ctl_model
        int cnt;
        cnt = 0;
        ctrlr_busy = 1'b0;
        d_rd = '0;
        error = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cnt = 0;
                ctrlr_busy = 1'b0;
            end else if (out_valid) begin
                ov_arr[ov_cnt] = {cmd, addr, d_in};
                d_rd  = resp_arr[ov_cnt][31:0];
                error = resp_arr[ov_cnt][33:32];
                ov_cnt++;
                cnt = ctl_lat;
                ctrlr_busy = (ctl_lat > 0);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) ctrlr_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [9:0] f;
        for (int by = 0; by < 4; by++) begin
            f = {1'b1, w[by*8 +: 8], 1'b0};
            for (int i = 0; i < 10; i++) begin
                srx = f[i];
                repeat (CPB) @(posedge clk);
                #1;
            end
        end
    endtask

    // Reference: expected host-visible words and controller strobes for one packet.
    task automatic run_pkt(input logic [3:0] c, input int n, input logic [31:0] base,
                           input bit corrupt, input string tag);
        logic [31:0] hdr, sum;
        logic [31:0] exp_tx [$];
        logic [67:0] exp_ov [$];
        logic [1:0]  eacc;
        bit          wr;
        int          tx0, ov0, cyc;
        hdr = {16'h0, 8'(n - 1), 4'h0, c};
        wr  = WMASK[c];
        tx0 = tx_cnt;
        ov0 = ov_cnt;
        if (n > MAXB) begin
            exp_tx.push_back(32'h0000_0E02);
            send_word(hdr);
        end else begin
            sum = hdr ^ base;
            if (wr) foreach (data_q[i]) sum ^= data_q[i];
            if (corrupt) sum ^= 32'h1;
            if (corrupt) begin
                exp_tx.push_back(32'h0000_0E01);
            end else begin
                exp_tx.push_back(32'h0000_00A5);
                eacc = 2'b00;
                for (int i = 0; i < n; i++) begin
                    resp_arr[ov0 + i] = resp_q[i];
                    exp_ov.push_back({c, base + 32'(i * STRIDE), wr ? data_q[i] : 32'h0});
                    exp_tx.push_back(resp_q[i][31:0]);
                    eacc |= resp_q[i][33:32];
                end
                exp_tx.push_back({30'h0, eacc});
            end
            send_word(hdr);
            send_word(base);
            if (wr) foreach (data_q[i]) send_word(data_q[i]);
            send_word(sum);
        end
        cyc = 0;
        while ((tx_cnt - tx0) < exp_tx.size() && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        repeat (300) @(posedge clk);
        #1;
        check({tag, " tx_words"}, 68'(tx_cnt - tx0), 68'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size(); i++)
            check($sformatf("%s tx%0d", tag, i), 68'(tx_arr[tx0 + i]), 68'(exp_tx[i]));
        check({tag, " strobes"}, 68'(ov_cnt - ov0), 68'(exp_ov.size()));
        for (int i = 0; i < exp_ov.size(); i++)
            check($sformatf("%s beat%0d", tag, i), ov_arr[ov0 + i], exp_ov[i]);
    endtask

    initial begin : main
        int tx0, ov0, cyc;
        reset_n = 1'b0;
        srx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset out_valid", 68'(out_valid), 68'(0));
        check("reset stx", 68'(stx), 68'(1));
        check("reset cmd", 68'(cmd), 68'(0));
        check("reset addr", 68'(addr), 68'(0));
        check("reset d_in", 68'(d_in), 68'(0));
        @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        resp_q = {34'h0_DEAD_BEEF};
        ctl_lat = 3;
        run_pkt(4'h3, 1, 32'h100, 1'b0, "single_read");

        data_q = {32'd1, 32'd2, 32'd3, 32'd4};
        resp_q = {34'h0_0000_0011, 34'h0_0000_0022, 34'h0_0000_0033, 34'h0_0000_0044};
        ctl_lat = 50;
        run_pkt(4'hC, 4, 32'h200, 1'b0, "write_burst");

        run_pkt(4'hC, 4, 32'h200, 1'b1, "bad_sum");
        ctl_lat = 2;
        run_pkt(4'hC, 4, 32'h200, 1'b0, "after_bad_sum");

        run_pkt(4'h3, 256, 32'h0, 1'b0, "oversize");
        data_q = {32'hCAFE_0000, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 32'hCAFE_0004,
                  32'hCAFE_0005, 32'hCAFE_0006, 32'hCAFE_0007, 32'hCAFE_0008, 32'hCAFE_0009,
                  32'hCAFE_000A, 32'hCAFE_000B, 32'hCAFE_000C, 32'hCAFE_000D, 32'hCAFE_000E,
                  32'hCAFE_000F};
        resp_q.delete();
        for (int i = 0; i < 16; i++) resp_q.push_back({2'd0, 32'(i)});
        ctl_lat = 0;
        run_pkt(4'hC, 16, 32'hFFFF_FFF0, 1'b0, "max_burst_wrap");

        tx0 = tx_cnt;
        ov0 = ov_cnt;
        send_word(32'h0000_0003);
        send_word(32'h0000_0400);
        repeat (1500) @(posedge clk);
        #1;
        check("timeout tx_words", 68'(tx_cnt - tx0), 68'(0));
        check("timeout strobes", 68'(ov_cnt - ov0), 68'(0));
        resp_q = {34'h0_1234_5678};
        run_pkt(4'h3, 1, 32'h400, 1'b0, "after_timeout");

        resp_q = {{2'd1, 32'hAAAA_0001}, {2'd2, 32'hAAAA_0002}};
        ctl_lat = 5;
        run_pkt(4'h3, 2, 32'h500, 1'b0, "err_agg");

        tx0 = tx_cnt;
        ov0 = ov_cnt;
        resp_arr[ov0] = 34'h0_0000_0001;
        resp_arr[ov0 + 1] = 34'h0_0000_0002;
        ctl_lat = 50;
        send_word(32'h0000_0103);
        send_word(32'h0000_0300);
        send_word(32'h0000_0103 ^ 32'h0000_0300);
        cyc = 0;
        while (ctrlr_busy !== 1'b1 && cyc < 20000) begin
            @(posedge clk);
            cyc++;
        end
        check("rst busy seen", 68'(ctrlr_busy), 68'(1));
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst out_valid", 68'(out_valid), 68'(0));
        check("rst stx", 68'(stx), 68'(1));
        check("rst addr", 68'(addr), 68'(0));
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (400) @(posedge clk);
        #1;
        check("rst tx_words", 68'(tx_cnt - tx0), 68'(1));
        check("rst ack", 68'(tx_arr[tx0]), 68'(32'h0000_00A5));
        check("rst strobes", 68'(ov_cnt - ov0), 68'(1));
        resp_q = {34'h3_0BAD_F00D};
        ctl_lat = 1;
        run_pkt(4'h3, 1, 32'h600, 1'b0, "after_reset");

        for (int p = 0; p < 4; p++) begin
            logic [3:0]  c;
            logic [31:0] base;
            int          n;
            c = 4'($urandom);
            if ($urandom_range(0, 1) == 1) c = 4'hC;
            n = $urandom_range(1, 4);
            base = $urandom;
            data_q.delete();
            resp_q.delete();
            for (int i = 0; i < n; i++) begin
                data_q.push_back($urandom);
                resp_q.push_back({2'($urandom_range(0, 3)), 32'($urandom)});
            end
            ctl_lat = $urandom_range(0, 12);
            run_pkt(c, n, base, 1'b0, $sformatf("rand%0d", p));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
